// File: rtl/range_wr_arbiter_if.sv
// ----------------------------------------------------------------------------
// range_wr_arbiter_if
// Groups the requester handshakes, the flush request, the range-buffer write
// and clear strobes and the status/statistics outputs of range_wr_arbiter.
//   bof_*   : heap-overflow tracker request (valid/first/last) and ready
//   dlk_*   : dataleak tracker request (valid/first/last) and ready
//   flush_i : buffer clear request
//   wr_*    : one-cycle write strobe plus the range being written
//   buf_rst_o, busy_o, wr_cnt_o, drop_cnt_o : clear strobe, status, counters
// master drives requests and observes the block; slave is the arbiter.
// ----------------------------------------------------------------------------
interface range_wr_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 8
);
    logic              bof_valid_i;
    logic [ADDR_W-1:0] bof_first_i;
    logic [ADDR_W-1:0] bof_last_i;
    logic              bof_ready_o;
    logic              dlk_valid_i;
    logic [ADDR_W-1:0] dlk_first_i;
    logic [ADDR_W-1:0] dlk_last_i;
    logic              dlk_ready_o;
    logic              flush_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_first_o;
    logic [ADDR_W-1:0] wr_last_o;
    logic              buf_rst_o;
    logic              busy_o;
    logic [CNT_W-1:0]  wr_cnt_o;
    logic [CNT_W-1:0]  drop_cnt_o;

    modport master (
        output bof_valid_i, bof_first_i, bof_last_i,
        output dlk_valid_i, dlk_first_i, dlk_last_i,
        output flush_i,
        input  bof_ready_o, dlk_ready_o,
        input  wr_en_o, wr_first_o, wr_last_o,
        input  buf_rst_o, busy_o, wr_cnt_o, drop_cnt_o
    );

    modport slave (
        input  bof_valid_i, bof_first_i, bof_last_i,
        input  dlk_valid_i, dlk_first_i, dlk_last_i,
        input  flush_i,
        output bof_ready_o, dlk_ready_o,
        output wr_en_o, wr_first_o, wr_last_o,
        output buf_rst_o, busy_o, wr_cnt_o, drop_cnt_o
    );
endinterface

// File: rtl/range_wr_arbiter.sv
// ----------------------------------------------------------------------------
// range_wr_arbiter
// Round-robin arbiter between the heap-overflow (bof) and dataleak (dlk)
// trackers in front of a shared range buffer. A granted range is written in a
// single WRITE cycle unless it is inverted (first > last) or repeats the last
// range written, in which case it is counted as dropped. A flush request
// clears the buffer by holding buf_rst_o for FLUSH_CYCLES cycles.
// Ports:
//   clk_i : clock, all state on rising edge
//   rst_i : asynchronous active-high reset
//   bus   : range_wr_arbiter_if slave (requests, flush, write, status)
// ----------------------------------------------------------------------------
module range_wr_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    range_wr_arbiter_if.slave bus
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StWrite, StFlush} state_e;

    state_e            r_state;
    logic              r_rr_dlk;      // 1: dlk wins the next tie
    logic              r_wr_en;
    logic              r_buf_rst;
    logic [ADDR_W-1:0] r_wr_first;
    logic [ADDR_W-1:0] r_wr_last;
    logic              r_lw_vld;      // last-written record valid
    logic [ADDR_W-1:0] r_lw_first;
    logic [ADDR_W-1:0] r_lw_last;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [CNT_W-1:0]  r_wr_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_idle;
    logic              w_grant;
    logic              w_take_bof;
    logic              w_take_dlk;
    logic [ADDR_W-1:0] w_sel_first;
    logic [ADDR_W-1:0] w_sel_last;
    logic              w_bad;
    logic              w_dup;

    // Ready is combinational and forced low during reset so outputs read 0.
    assign w_idle     = (r_state == StIdle) && !rst_i;
    assign w_grant    = w_idle && !bus.flush_i && (bus.bof_valid_i || bus.dlk_valid_i);
    assign w_take_bof = w_grant && bus.bof_valid_i && (!bus.dlk_valid_i || !r_rr_dlk);
    assign w_take_dlk = w_grant && !w_take_bof;

    assign w_sel_first = w_take_dlk ? bus.dlk_first_i : bus.bof_first_i;
    assign w_sel_last  = w_take_dlk ? bus.dlk_last_i  : bus.bof_last_i;

    // Range qualification is done on the grant edge so a discarded range never
    // disturbs wr_first_o/wr_last_o and the block is free again next cycle.
    assign w_bad = (w_sel_first > w_sel_last);
    assign w_dup = r_lw_vld && (w_sel_first == r_lw_first) && (w_sel_last == r_lw_last);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_rr_dlk    <= 1'b0;
            r_wr_en     <= 1'b0;
            r_buf_rst   <= 1'b0;
            r_wr_first  <= '0;
            r_wr_last   <= '0;
            r_lw_vld    <= 1'b0;
            r_lw_first  <= '0;
            r_lw_last   <= '0;
            r_flush_cnt <= '0;
            r_wr_cnt    <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.flush_i) begin
                        r_state     <= StFlush;
                        r_buf_rst   <= 1'b1;
                        r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
                    end else if (w_grant) begin
                        r_rr_dlk <= w_take_bof;
                        if (w_bad || w_dup) begin
                            if (r_drop_cnt != {CNT_W{1'b1}}) begin
                                r_drop_cnt <= r_drop_cnt + 1'b1;
                            end
                        end else begin
                            r_state    <= StWrite;
                            r_wr_en    <= 1'b1;
                            r_wr_first <= w_sel_first;
                            r_wr_last  <= w_sel_last;
                        end
                    end
                end
                StWrite: begin
                    r_lw_vld   <= 1'b1;
                    r_lw_first <= r_wr_first;
                    r_lw_last  <= r_wr_last;
                    if (r_wr_cnt != {CNT_W{1'b1}}) begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                    end
                    r_state <= StIdle;
                end
                StFlush: begin
                    if (r_flush_cnt == '0) begin
                        r_state   <= StIdle;
                        r_buf_rst <= 1'b0;
                        r_lw_vld  <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= StIdle;
                    r_buf_rst <= 1'b0;
                end
            endcase
        end
    end

    assign bus.bof_ready_o = w_take_bof;
    assign bus.dlk_ready_o = w_take_dlk;
    assign bus.wr_en_o     = r_wr_en;
    assign bus.wr_first_o  = r_wr_first;
    assign bus.wr_last_o   = r_wr_last;
    assign bus.buf_rst_o   = r_buf_rst;
    assign bus.busy_o      = (r_state != StIdle) || w_grant;
    assign bus.wr_cnt_o    = r_wr_cnt;
    assign bus.drop_cnt_o  = r_drop_cnt;

endmodule

// File: doc/range_wr_arbiter.md
RANGE_WR_ARBITER -- requirements
Module: range_wr_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, range-address width.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 4, number of cycles buf_rst_o stays asserted per flush (minimum 1).
REQ-003 The block SHALL have parameter CNT_W, default 8, statistics counter width.
REQ-004 The block SHALL have ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-high reset.
- bof_valid_i  in  1  heap-overflow tracker has a range to record.
- bof_first_i  in  ADDR_W  range start address.
- bof_last_i  in  ADDR_W  range end address.
- bof_ready_o  out  1  heap-overflow request accepted this cycle.
- dlk_valid_i  in  1  dataleak tracker has a range to record.
- dlk_first_i  in  ADDR_W  range start address.
- dlk_last_i  in  ADDR_W  range end address.
- dlk_ready_o  out  1  dataleak request accepted this cycle.
- flush_i  in  1  request to clear the range buffer.
- wr_en_o  out  1  one-cycle write strobe to the range buffer.
- wr_first_o  out  ADDR_W  start address being written.
- wr_last_o  out  ADDR_W  end address being written.
- buf_rst_o  out  1  clear strobe to the range buffer.
- busy_o  out  1  block is not in IDLE.
- wr_cnt_o  out  CNT_W  saturating count of buffer writes.
- drop_cnt_o  out  CNT_W  saturating count of accepted-but-discarded requests.

Function
REQ-005 The block SHALL implement the states IDLE, WRITE and FLUSH.
REQ-006 In IDLE with flush_i=1, the block SHALL go to FLUSH and SHALL accept no request that cycle, because flush has priority over both requesters.
REQ-007 In IDLE with flush_i=0 and at least one valid, the block SHALL grant exactly one requester by asserting its ready_o combinationally in the same cycle.
REQ-008 With both requesters valid, the block SHALL grant the one not granted most recently (round-robin); the pointer SHALL reset to favour bof.
REQ-009 A granted request SHALL have its first/last captured into registers on the grant edge; a handshake is valid and ready_o high at the same clock edge.
REQ-010 A captured range with first > last (unsigned) SHALL be discarded: drop_cnt_o increments and the block returns to IDLE with no write.
REQ-011 A captured range equal in both first and last to the last range written SHALL be discarded the same way (duplicate suppression).
REQ-012 Otherwise the block SHALL enter WRITE for exactly one cycle, driving wr_en_o=1 and the captured values on wr_first_o/wr_last_o, then increment wr_cnt_o and return to IDLE.
REQ-013 Sustained throughput SHALL be at most one write per 2 cycles; ready_o SHALL be 0 outside IDLE.
REQ-014 wr_first_o/wr_last_o SHALL hold their last value when wr_en_o=0.
REQ-015 FLUSH SHALL assert buf_rst_o for exactly FLUSH_CYCLES consecutive cycles using a down-counter, then return to IDLE.
REQ-016 Completing FLUSH SHALL clear the last-written-range record, so that a following identical range is written rather than suppressed.
REQ-017 flush_i asserted in WRITE or FLUSH SHALL NOT be latched; a requester must hold flush_i until busy_o=0.
REQ-018 A flush SHALL NOT reset wr_cnt_o or drop_cnt_o; both counters SHALL saturate at all-ones and never wrap.
REQ-019 busy_o SHALL be 1 in WRITE and FLUSH and in the cycle a capture occurs.

Reset
REQ-020 While rst_i=1 the block SHALL be in IDLE with all outputs 0, the counters 0, the RR pointer on bof and the last-range record invalid, independent of clk_i.
REQ-021 Reset asserted mid-WRITE or mid-FLUSH SHALL abort immediately, with no further wr_en_o or buf_rst_o pulse after release.

Verification
REQ-022 Single bof request with first=0x100, last=0x120 SHALL give bof_ready_o=1 in cycle 0, wr_en_o=1 in cycle 1 with 0x100/0x120, and wr_cnt_o=1.
REQ-023 bof and dlk valid together for 4 requests SHALL be granted in the order bof, dlk, bof, dlk, with writes spaced 2 cycles apart.
REQ-024 A request with first=0x200, last=0x1FF SHALL cause no wr_en_o and drop_cnt_o=1; an identical repeat of 0x100/0x120 SHALL also be dropped, giving drop_cnt_o=2.
REQ-025 flush_i and bof_valid_i asserted together SHALL give buf_rst_o for 4 cycles, then the bof grant; re-sending the previous range afterwards SHALL be written.
REQ-026 rst_i pulsed during FLUSH cycle 2 SHALL deassert buf_rst_o asynchronously and clear the counters.
REQ-027 With CNT_W=2, six accepted writes SHALL leave wr_cnt_o=3.
